// File: rtl/uart_bus_pkg.sv
// Shared constants for the UART bus controller: default register map, CON bit layout, TX sequencer states.
// No logic lives here.
package uart_bus_pkg;

   localparam logic [31:0] DEF_BASE_TXD = 32'h4000_0018;
   localparam logic [31:0] DEF_BASE_RXD = 32'h4000_001C;
   localparam logic [31:0] DEF_BASE_CON = 32'h4000_0020;

   localparam int CON_TX_IE    = 0;
   localparam int CON_RX_IE    = 1;
   localparam int CON_TX_DONE  = 2;
   localparam int CON_RX_VALID = 3;
   localparam int CON_TX_BUSY  = 4;
   localparam int CON_RX_OVF   = 5;

   typedef enum logic [1:0] {
      T_IDLE      = 2'd0,
      T_START     = 2'd1,
      T_WAIT_BUSY = 2'd2,
      T_WAIT_DONE = 2'd3
   } tx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Generic synchronous FIFO; head is combinational from the read pointer, push/pop take effect at the clock edge.
// A push while full is accepted only when a pop frees the slot in the same cycle; otherwise it is refused.
module uart_rx_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   // Extra pointer MSB distinguishes full from empty when the indices coincide.
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/uart_bus_ctrl.sv
// Memory-mapped UART controller: TXD/RXD/CON registers, RX byte FIFO, TX start/busy/done sequencer, level irq.
// RX push 2 clk after the strobe is first sampled; TX_EN 1 clk after a TXD write; TXD writes while busy are dropped.
module uart_bus_ctrl
   import uart_bus_pkg::*;
#(
   parameter int          RX_DEPTH = 4,
   parameter logic [31:0] BASE_TXD = DEF_BASE_TXD,
   parameter logic [31:0] BASE_RXD = DEF_BASE_RXD,
   parameter logic [31:0] BASE_CON = DEF_BASE_CON
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic        rd_en,
   input  logic        wr_en,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   input  logic        RX_STATUS,
   input  logic [7:0]  RX_DATA,
   input  logic        TX_STATUS,
   output logic        TX_EN,
   output logic [7:0]  TX_DATA,
   output logic        irq
);

   logic       rx_s1, rx_s2, rx_prev;
   logic       tx_s1, tx_s2;
   logic       tx_idle;
   logic       rx_push;
   logic       rx_pop;
   logic [7:0] rx_head;
   logic       rx_full;
   logic       rx_empty;
   logic       rx_valid;

   logic       tx_ie, rx_ie, tx_done, rx_ovf;
   logic [7:0] hold;
   logic       hold_valid;
   logic       tx_busy;

   tx_state_t  state, state_nxt;
   logic       tx_start;
   logic       set_done;

   logic       txd_wr, con_wr, con_rd, rxd_rd;
   logic [31:0] con_val;
   logic       unused_wdata;

   assign unused_wdata = ^wdata[31:8];

   assign txd_wr = wr_en && (addr == BASE_TXD);
   assign con_wr = wr_en && (addr == BASE_CON);
   assign con_rd = rd_en && (addr == BASE_CON);
   assign rxd_rd = rd_en && (addr == BASE_RXD);

   assign tx_idle  = tx_s2;
   assign rx_push  = rx_s2 && !rx_prev;
   assign rx_pop   = rxd_rd && !rx_empty;
   assign rx_valid = !rx_empty;
   assign tx_busy  = hold_valid || (state != T_IDLE);

   uart_rx_fifo #(
      .DEPTH (RX_DEPTH),
      .WIDTH (8)
   ) u_rx_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (rx_push),
      .din   (RX_DATA),
      .pop   (rx_pop),
      .head  (rx_head),
      .full  (rx_full),
      .empty (rx_empty)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= T_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      tx_start  = 1'b0;
      set_done  = 1'b0;
      case (state)
         T_IDLE: begin
            if (hold_valid && tx_idle) state_nxt = T_START;
         end
         T_START: begin
            tx_start  = 1'b1;
            state_nxt = T_WAIT_BUSY;
         end
         T_WAIT_BUSY: begin
            if (!tx_idle) state_nxt = T_WAIT_DONE;
         end
         T_WAIT_DONE: begin
            if (tx_idle) begin
               set_done  = 1'b1;
               state_nxt = T_IDLE;
            end
         end
         default: state_nxt = T_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_s1      <= 1'b0;
         rx_s2      <= 1'b0;
         rx_prev    <= 1'b0;
         tx_s1      <= 1'b0;
         tx_s2      <= 1'b0;
         tx_ie      <= 1'b0;
         rx_ie      <= 1'b0;
         tx_done    <= 1'b0;
         rx_ovf     <= 1'b0;
         hold       <= 8'h00;
         hold_valid <= 1'b0;
      end else begin
         rx_s1   <= RX_STATUS;
         rx_s2   <= rx_s1;
         rx_prev <= rx_s2;
         tx_s1   <= TX_STATUS;
         tx_s2   <= tx_s1;

         if (con_wr) begin
            tx_ie <= wdata[CON_TX_IE];
            rx_ie <= wdata[CON_RX_IE];
         end

         // Sticky bits: a set event in the clearing read's cycle must not be lost.
         if (set_done)    tx_done <= 1'b1;
         else if (con_rd) tx_done <= 1'b0;

         if (rx_push && rx_full && !rx_pop) rx_ovf <= 1'b1;
         else if (con_rd)                   rx_ovf <= 1'b0;

         if (txd_wr && !tx_busy) begin
            hold       <= wdata[7:0];
            hold_valid <= 1'b1;
         end else if (tx_start) begin
            hold_valid <= 1'b0;
         end
      end
   end

   always_comb begin
      con_val               = '0;
      con_val[CON_TX_IE]    = tx_ie;
      con_val[CON_RX_IE]    = rx_ie;
      con_val[CON_TX_DONE]  = tx_done;
      con_val[CON_RX_VALID] = rx_valid;
      con_val[CON_TX_BUSY]  = tx_busy;
      con_val[CON_RX_OVF]   = rx_ovf;
   end

   always_comb begin
      rdata = '0;
      if (rxd_rd && rx_valid) rdata = {24'h0, rx_head};
      else if (con_rd)        rdata = con_val;
   end

   assign TX_EN   = tx_start;
   assign TX_DATA = tx_start ? hold : 8'h00;
   assign irq     = (tx_ie && tx_done) || (rx_ie && rx_valid);

endmodule

// File: tb/tb_uart_bus_ctrl.sv
// Directed bench for uart_bus_ctrl: inputs change on the falling edge, outputs are sampled just after it.
module tb_uart_bus_ctrl;

   localparam logic [31:0] A_TXD = 32'h4000_0018;
   localparam logic [31:0] A_RXD = 32'h4000_001C;
   localparam logic [31:0] A_CON = 32'h4000_0020;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] addr;
   logic        rd_en;
   logic        wr_en;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        RX_STATUS;
   logic [7:0]  RX_DATA;
   logic        TX_STATUS;
   logic        TX_EN;
   logic [7:0]  TX_DATA;
   logic        irq;

   int passed = 0;
   int total  = 0;
   int fails  = 0;

   uart_bus_ctrl #(
      .RX_DEPTH (4),
      .BASE_TXD (A_TXD),
      .BASE_RXD (A_RXD),
      .BASE_CON (A_CON)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .addr      (addr),
      .rd_en     (rd_en),
      .wr_en     (wr_en),
      .wdata     (wdata),
      .rdata     (rdata),
      .RX_STATUS (RX_STATUS),
      .RX_DATA   (RX_DATA),
      .TX_STATUS (TX_STATUS),
      .TX_EN     (TX_EN),
      .TX_DATA   (TX_DATA),
      .irq       (irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Single-cycle read; returns at the next falling edge with rd_en dropped.
   task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
      addr  = a;
      rd_en = 1'b1;
      #1 d = rdata;
      @(negedge clk);
      rd_en = 1'b0;
      addr  = '0;
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      addr  = a;
      wdata = d;
      wr_en = 1'b1;
      @(negedge clk);
      wr_en = 1'b0;
      addr  = '0;
      wdata = '0;
   endtask

   task automatic push_byte(input logic [7:0] b);
      RX_DATA   = b;
      RX_STATUS = 1'b1;
      step(2);
      RX_STATUS = 1'b0;
      step(3);
   endtask

   initial begin
      logic [31:0] d;
      int pulses;

      reset = 1'b1; addr = '0; rd_en = 1'b0; wr_en = 1'b0; wdata = '0;
      RX_STATUS = 1'b0; RX_DATA = 8'h00; TX_STATUS = 1'b1;

      // Reset state
      step(2);
      #1;
      check("rst_rdata", rdata, 32'h0);
      check("rst_tx_en", {31'h0, TX_EN}, 32'h0);
      check("rst_tx_data", {24'h0, TX_DATA}, 32'h0);
      check("rst_irq", {31'h0, irq}, 32'h0);
      @(negedge clk);
      bus_read(A_CON, d);
      check("rst_con", d, 32'h0);
      reset = 1'b0;
      step(3);

      // One long RX strobe -> exactly one push, visible after edge k+2
      RX_DATA   = 8'hA5;
      RX_STATUS = 1'b1;
      step(2);
      bus_read(A_CON, d);
      check("rx_lat_before", d, 32'h00);
      bus_read(A_CON, d);
      check("rx_lat_k3", d, 32'h08);
      step(16);
      RX_STATUS = 1'b0;
      step(3);
      bus_read(A_RXD, d);
      check("rx_a5", d, 32'hA5);
      bus_read(A_CON, d);
      check("rx_single_push", d, 32'h00);
      bus_read(A_RXD, d);
      check("rx_empty_read", d, 32'h00);

      // Overflow with five pushes into a four-deep FIFO
      for (int i = 1; i <= 5; i++) push_byte(8'(i));
      bus_read(A_CON, d);
      check("ovf_con", d, 32'h28);
      for (int i = 1; i <= 4; i++) begin
         bus_read(A_RXD, d);
         check("ovf_order", d, 32'(i));
      end
      bus_read(A_RXD, d);
      check("ovf_drained", d, 32'h00);
      bus_read(A_CON, d);
      check("ovf_cleared", d, 32'h00);

      // Push and pop on the same edge while full
      for (int i = 1; i <= 4; i++) push_byte(8'(i));
      RX_DATA   = 8'h66;
      RX_STATUS = 1'b1;
      step(2);
      bus_read(A_RXD, d);
      check("pp_head", d, 32'h01);
      RX_STATUS = 1'b0;
      step(3);
      bus_read(A_CON, d);
      check("pp_no_ovf", d, 32'h08);
      bus_read(A_RXD, d); check("pp_02", d, 32'h02);
      bus_read(A_RXD, d); check("pp_03", d, 32'h03);
      bus_read(A_RXD, d); check("pp_04", d, 32'h04);
      bus_read(A_RXD, d); check("pp_new", d, 32'h66);
      bus_read(A_RXD, d); check("pp_empty", d, 32'h00);

      // Enable both interrupts, then transmit 3C
      bus_write(A_CON, 32'h3);
      #1 check("ie_irq_idle", {31'h0, irq}, 32'h0);
      bus_read(A_CON, d);
      check("ie_con", d, 32'h03);
      bus_write(A_TXD, 32'h3C);
      #1 check("tx_en_n", {31'h0, TX_EN}, 32'h0);
      bus_read(A_CON, d);
      check("tx_busy_hold", d, 32'h13);
      #1 check("tx_en_pulse", {31'h0, TX_EN}, 32'h1);
      check("tx_data", {24'h0, TX_DATA}, 32'h3C);
      bus_write(A_TXD, 32'h55);
      #1 check("tx_en_end", {31'h0, TX_EN}, 32'h0);
      check("tx_data_end", {24'h0, TX_DATA}, 32'h0);
      TX_STATUS = 1'b0;
      pulses = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         #1 if (TX_EN) pulses++;
      end
      check("tx_no_repulse", 32'(pulses), 32'h0);
      @(negedge clk);
      TX_STATUS = 1'b1;
      step(2);
      #1 check("tx_done_early", {31'h0, irq}, 32'h0);
      step(1);
      #1 check("tx_done_irq", {31'h0, irq}, 32'h1);
      @(negedge clk);
      bus_read(A_CON, d);
      check("tx_done_con", d, 32'h07);
      #1 check("irq_cleared", {31'h0, irq}, 32'h0);
      pulses = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #1 if (TX_EN) pulses++;
      end
      check("tx_busy_write_ignored", 32'(pulses), 32'h0);
      @(negedge clk);
      bus_read(A_CON, d);
      check("tx_after_con", d, 32'h03);

      // Reset while the transmitter is in progress with two bytes queued
      push_byte(8'h11);
      push_byte(8'h22);
      #1 check("pre_rst_irq", {31'h0, irq}, 32'h1);
      @(negedge clk);
      bus_write(A_TXD, 32'hAA);
      step(1);
      TX_STATUS = 1'b0;
      step(4);
      bus_read(A_CON, d);
      check("wait_done_con", d, 32'h1B);
      reset     = 1'b1;
      TX_STATUS = 1'b1;
      step(1);
      #1;
      check("mid_rst_tx_en", {31'h0, TX_EN}, 32'h0);
      check("mid_rst_tx_data", {24'h0, TX_DATA}, 32'h0);
      check("mid_rst_irq", {31'h0, irq}, 32'h0);
      check("mid_rst_rdata", rdata, 32'h0);
      @(negedge clk);
      bus_read(A_CON, d);
      check("mid_rst_con", d, 32'h0);
      bus_read(A_RXD, d);
      check("mid_rst_fifo", d, 32'h0);
      reset  = 1'b0;
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         #1 if (TX_EN) pulses++;
      end
      check("post_rst_no_tx", 32'(pulses), 32'h0);
      @(negedge clk);
      bus_read(A_CON, d);
      check("post_rst_con", d, 32'h0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
